// File: rtl/btn_step_conditioner_pkg.sv
// Shared definitions for the button step conditioner: debounce FSM state
// encoding, direction levels and the saturating sample-counter helper.
package btn_step_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARM     = 2'b01,
    PRESSED = 2'b10,
    RELEASE = 2'b11
  } db_state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int         CNT_W   = 4;
  localparam logic [3:0] CNT_MAX = 4'hF;

  // Sample counter never wraps: it sticks at its maximum.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// One button: two-flop synchroniser followed by a tick-sampled debounce FSM.
// press_evt pulses for one clk when a press is accepted; active is high
// whenever the FSM is outside IDLE.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | button released and stable
// ARM     | counting consecutive high samples towards an accepted press
// PRESSED | press accepted, button still held
// RELEASE | counting consecutive low samples towards a full release
module btn_debounce_fsm
  import btn_step_conditioner_pkg::*;
#(
  parameter int DB_COUNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic press_evt,
  output logic active
);

  localparam logic [CNT_W-1:0] DB_TARGET = CNT_W'(DB_COUNT);

  logic             sync_1;
  logic             sync_2;
  db_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_nxt = sat_inc(cnt);
  assign active  = (state != IDLE);

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  // Debounce FSM, advanced only on prescaler ticks; a bounce during release
  // drops back to PRESSED without raising another press event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      press_evt <= 1'b0;
    end else begin
      press_evt <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (sync_2) begin
              state <= ARM;
              cnt   <= 4'd1;
            end
          end
          ARM: begin
            if (sync_2) begin
              if (cnt_nxt == DB_TARGET) begin
                state     <= PRESSED;
                cnt       <= '0;
                press_evt <= 1'b1;
              end else begin
                cnt <= cnt_nxt;
              end
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          PRESSED: begin
            if (!sync_2) begin
              state <= RELEASE;
              cnt   <= 4'd1;
            end
          end
          RELEASE: begin
            if (!sync_2) begin
              if (cnt_nxt == DB_TARGET) begin
                state <= IDLE;
                cnt   <= '0;
              end else begin
                cnt <= cnt_nxt;
              end
            end else begin
              state <= PRESSED;
              cnt   <= '0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/btn_step_conditioner.sv
// Front end for the up/down counter: debounces the up and down buttons and
// emits one step pulse per accepted press with a registered direction level.
module btn_step_conditioner
  import btn_step_conditioner_pkg::*;
#(
  parameter int CLK_DIV  = 10000,
  parameter int DB_COUNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up_raw,
  input  logic btn_dn_raw,
  output logic step,
  output logic up,
  output logic busy
);

  localparam int              PS_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);

  logic [PS_W-1:0] ps_cnt;
  logic            tick;
  logic            press_up;
  logic            press_dn;
  logic            active_up;
  logic            active_dn;

  assign tick = (ps_cnt == PS_LAST);

  // Free-running debounce sample prescaler, 0..CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_cnt <= '0;
    end else if (tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  btn_debounce_fsm #(.DB_COUNT(DB_COUNT)) u_db_up (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .raw       (btn_up_raw),
    .press_evt (press_up),
    .active    (active_up)
  );

  btn_debounce_fsm #(.DB_COUNT(DB_COUNT)) u_db_dn (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .raw       (btn_dn_raw),
    .press_evt (press_dn),
    .active    (active_dn)
  );

  // Output stage: a press on exactly one button steps the counter; presses
  // landing on the same clk cancel and leave the direction untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      step <= 1'b0;
      up   <= DIR_UP;
      busy <= 1'b0;
    end else begin
      step <= press_up ^ press_dn;
      if (press_up && !press_dn) begin
        up <= DIR_UP;
      end else if (press_dn && !press_up) begin
        up <= DIR_DN;
      end
      busy <= active_up | active_dn;
    end
  end

endmodule

// File: doc/btn_step_conditioner.md
Name: btn_step_conditioner

Overview:
- Upstream front end for the up/down counter stage.
- Takes two raw push-buttons (count-up, count-down) from the board and synchronises and debounces them.
- Turns each clean press into a single-cycle step pulse plus a registered direction level (up: 1 = increment, 0 = decrement).
- The counter stage consumes both outputs: it advances once per press, not once per clock.

Parameters:
- CLK_DIV, 10000: clk cycles per debounce sample tick; legal range 2..65535.
- DB_COUNT, 4: consecutive equal samples required to accept a press or release; legal range 2..15.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset; clock clk
- btn_up_raw  input  1  asynchronous raw up button, active-high
- btn_dn_raw  input  1  asynchronous raw down button, active-high
- step  output  1  one-clk pulse per accepted press
- up  output  1  direction of the most recent accepted step; 1 = up
- busy  output  1  high while either button is outside its IDLE state

Behaviour:
- Reset values:
  - All outputs: step=0, up=1, busy=0.
  - Internal state: synchroniser flops=0, prescaler=0, both FSMs IDLE, sample counters=0.
  - Reset mid-press abandons the press; no step is issued for it.
- Synchroniser: 2-flop chain per button; only the second-stage output is used downstream.
- Prescaler:
  - Counter runs 0..CLK_DIV-1 and wraps to 0.
  - tick=1 for exactly one clk when the counter equals CLK_DIV-1.
  - Width is ceil(log2(CLK_DIV)).
- Per-button FSM (evaluated only on tick; holds state otherwise):
  - IDLE: sync=1 -> ARM, cnt=1.
  - ARM:
    - sync=1: cnt+1; when cnt+1==DB_COUNT -> PRESSED and assert press_evt for that clk.
    - sync=0 -> IDLE, cnt=0.
  - PRESSED: sync=0 -> RELEASE, cnt=1.
  - RELEASE:
    - sync=0: cnt+1; when cnt+1==DB_COUNT -> IDLE, cnt=0.
    - sync=1 -> PRESSED, cnt=0, with no new press_evt (bounce on release).
  - cnt is 4 bits and saturates; it never wraps.
- Output stage (registered, one clk after press_evt):
  - press_up only: step=1, up=1.
  - press_dn only: step=1, up=0.
  - Both in the same clk: step=0, up unchanged (conflict discarded).
  - Otherwise: step=0, up holds.
- busy is registered: OR of (state!=IDLE) across both FSMs.
- Latency:
  - From a clean raw rise, step asserts after 2 sync clks + (DB_COUNT-1 to DB_COUNT) ticks + 1 clk.
  - Holding a button produces no further steps.
  - A new step requires a full release (DB_COUNT low samples) followed by a new press.
- Spurious pulses shorter than DB_COUNT ticks produce no step.
- Simultaneous presses whose press_evt fall in different clks each produce their own step, in order.

Decomposition:
- Shared package holds:
  - FSM state encoding constants: IDLE=2'b00, ARM=2'b01, PRESSED=2'b10, RELEASE=2'b11.
  - Direction constants DIR_UP=1, DIR_DN=0.
- One sub-module, btn_debounce_fsm:
  - Contains the synchroniser and the 4-state FSM with counter.
  - Inputs: clk, reset, tick, raw. Outputs: press_evt, active.
  - Instantiated twice.
- The prescaler and output stage live in the top.

Test Plan (sim params CLK_DIV=4, DB_COUNT=3):
- Reset with both buttons low for 20 clks -> step=0, up=1, busy=0 throughout.
- btn_up_raw held high for 40 clks -> exactly one step pulse (one clk wide) within 10-15 clks of the rise, with up=1; no further steps while held.
- btn_up_raw bounces (high 4 clks, low 4, high 4), then is held high -> exactly one step, after stability; zero steps from the bounce portion.
- Full up press/release, then btn_dn_raw press -> step with up=0; up stays 0 afterwards until the next up press.
- btn_up_raw and btn_dn_raw rise on the same clk, held 40 clks -> no step; up unchanged from its prior value.
- Reset asserted while the up FSM is in ARM (after 1 accepted sample) -> no step ever issued for that press; busy=0 the clk after reset.
